// File: rtl/noc_switch_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_switch_allocator_if
//  Description : Request/grant and crossbar-select bundle between the router
//                input stage and the 5x5 switch allocator.
//  Revision    : 1.0  initial release
// ============================================================================
interface noc_switch_allocator_if;
   logic [4:0]  req_i;
   logic [14:0] dest_i;
   logic [4:0]  tail_i;
   logic [4:0]  out_ready_i;
   logic [2:0]  N_port_select;
   logic [2:0]  S_port_select;
   logic [2:0]  E_port_select;
   logic [2:0]  W_port_select;
   logic [2:0]  L_port_select;
   logic [4:0]  gnt_o;
   logic [4:0]  out_valid_o;
   logic        err_o;
   logic        timeout_o;

   modport master (
      output req_i, dest_i, tail_i, out_ready_i,
      input  N_port_select, S_port_select, E_port_select, W_port_select, L_port_select,
      input  gnt_o, out_valid_o, err_o, timeout_o
   );

   modport slave (
      input  req_i, dest_i, tail_i, out_ready_i,
      output N_port_select, S_port_select, E_port_select, W_port_select, L_port_select,
      output gnt_o, out_valid_o, err_o, timeout_o
   );
endinterface
`default_nettype wire

// File: rtl/noc_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : noc_switch_allocator
//  Description : 5x5 crossbar switch allocator, one round-robin arbiter per
//                output, each output locked to one input from head to tail.
//                Optional stall timeout: define SA_LOCK_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module noc_switch_allocator #(
   parameter int NUM_PORTS      = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   noc_switch_allocator_if.slave  sa
);

   localparam int C_PORTS  = 5;
   localparam bit C_CFG_OK = (NUM_PORTS == C_PORTS) &&
                             (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 255);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   logic [2:0]                 w_dest [C_PORTS];
   logic [C_PORTS-1:0]         w_illegal;
   logic [C_PORTS-1:0]         w_xfer_v;
   logic [C_PORTS-1:0]         w_expire_v;
   logic [C_PORTS-1:0][2:0]    w_owner_v;
   logic [C_PORTS-1:0]         w_gnt;
   logic                       err_q;

   always_comb begin
      for (int i = 0; i < C_PORTS; i++) begin
         w_dest[i]    = sa.dest_i[3*i +: 3];
         w_illegal[i] = sa.req_i[i] && ((w_dest[i] > 3'd4) || (w_dest[i] == 3'(i)));
      end
   end

   for (genvar o = 0; o < C_PORTS; o++) begin : g_out
      state_t             state_q, state_d;
      logic [2:0]         owner_q, owner_d;
      logic [2:0]         rr_ptr_q, rr_ptr_d;
      logic [C_PORTS-1:0] w_elig;
      logic [3:0]         w_sum;
      logic [2:0]         w_winner;
      logic               w_found;
      logic               w_xfer;
      logic               w_expire;
      logic [2:0]         w_next_ptr;

      // A request aimed at this output is legal only from another port.
      always_comb begin
         for (int i = 0; i < C_PORTS; i++) begin
            w_elig[i] = sa.req_i[i] && (w_dest[i] == 3'(o)) && (i != o);
         end
      end

      always_comb begin
         w_found  = 1'b0;
         w_winner = owner_q;
         w_sum    = '0;
         for (int k = 0; k < C_PORTS; k++) begin
            w_sum = {1'b0, rr_ptr_q} + 4'(k);
            if (w_sum >= 4'd5) begin
               w_sum = w_sum - 4'd5;
            end
            if (!w_found && w_elig[w_sum[2:0]]) begin
               w_found  = 1'b1;
               w_winner = w_sum[2:0];
            end
         end
      end

      assign w_xfer = !rst && (state_q == ST_LOCKED) && sa.req_i[owner_q] &&
                      (w_dest[owner_q] == 3'(o)) && sa.out_ready_i[o];

      assign w_next_ptr = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;

`ifdef SA_LOCK_TIMEOUT_EN
      logic [7:0] stall_q, stall_d;

      always_comb begin
         stall_d  = '0;
         w_expire = 1'b0;
         if (state_q == ST_LOCKED && !w_xfer) begin
            if (stall_q == 8'(TIMEOUT_CYCLES - 1)) begin
               w_expire = 1'b1;
            end else begin
               stall_d = stall_q + 8'd1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            stall_q <= '0;
         end else begin
            stall_q <= stall_d;
         end
      end
`else
      assign w_expire = 1'b0;
`endif

      always_comb begin
         state_d  = state_q;
         owner_d  = owner_q;
         rr_ptr_d = rr_ptr_q;
         case (state_q)
            ST_IDLE: begin
               if (w_found) begin
                  state_d = ST_LOCKED;
                  owner_d = w_winner;
               end
            end
            ST_LOCKED: begin
               if ((w_xfer && sa.tail_i[owner_q]) || w_expire) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = w_next_ptr;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Owner resets to the output's own index so every select is defined.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 3'(o);
            rr_ptr_q <= '0;
         end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
         end
      end

      assign w_xfer_v[o]   = w_xfer;
      assign w_expire_v[o] = w_expire;
      assign w_owner_v[o]  = owner_q;
   end

   always_comb begin
      w_gnt = '0;
      for (int o = 0; o < C_PORTS; o++) begin
         if (w_xfer_v[o]) begin
            w_gnt[w_owner_v[o]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= |w_illegal;
      end
   end

`ifdef SA_LOCK_TIMEOUT_EN
   logic timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= |w_expire_v;
      end
   end

   assign sa.timeout_o = timeout_q;
`else
   assign sa.timeout_o = 1'b0;
`endif

   assign sa.N_port_select = w_owner_v[0];
   assign sa.S_port_select = w_owner_v[1];
   assign sa.E_port_select = w_owner_v[2];
   assign sa.W_port_select = w_owner_v[3];
   assign sa.L_port_select = w_owner_v[4];
   assign sa.gnt_o         = w_gnt;
   assign sa.out_valid_o   = w_xfer_v;
   assign sa.err_o         = err_q;

   a_cfg   : assert property (@(posedge clk) C_CFG_OK);
   a_grant : assert property (@(posedge clk) $countones(w_gnt) == $countones(w_xfer_v));

endmodule
`default_nettype wire

// File: tb/tb_noc_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_switch_allocator
//  Description : Randomised packet traffic against a queue-based scoreboard
//                fed by a behavioural model of the switch allocator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noc_switch_allocator;

`ifdef SA_LOCK_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 64;
`endif

   typedef struct {
      logic [4:0]  gnt;
      logic [4:0]  vld;
      logic [14:0] sel;
      logic        err;
      logic        tmo;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   noc_switch_allocator_if sa_if ();

   noc_switch_allocator #(
      .NUM_PORTS      (5),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sa  (sa_if)
   );

   always #5 clk = ~clk;

   exp_t       exp_q [$];
   int         n_checks = 0;
   int         n_fail   = 0;

   // Model state: per-output lock, owner, round-robin pointer, stall count.
   bit         m_lock  [5];
   int         m_own   [5];
   int         m_ptr   [5];
   int         m_stall [5];
   bit         m_err;
   bit         m_tmo;

   // Traffic generator state per input.
   int         rem     [5];
   int         pdest   [5];
   int         ill_age [5];
   logic [4:0] rdy_block = '0;

   task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: actual=%h required=%h", nm, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < 5; o++) begin
         m_lock[o]  = 1'b0;
         m_own[o]   = o;
         m_ptr[o]   = 0;
         m_stall[o] = 0;
      end
      m_err = 1'b0;
      m_tmo = 1'b0;
   endtask

   task automatic cycle(input logic r, input logic [4:0] req, input logic [14:0] dest,
                        input logic [4:0] tail, input logic [4:0] rdy, output logic [4:0] egnt);
      exp_t e;
      int   d  [5];
      bit   xf [5];
      bit   found;
      int   cand;
      @(posedge clk);
      #1;
      rst               = r;
      sa_if.req_i       = req;
      sa_if.dest_i      = dest;
      sa_if.tail_i      = tail;
      sa_if.out_ready_i = rdy;
      for (int i = 0; i < 5; i++) d[i] = int'((dest >> (3 * i)) & 15'h7);

      e.gnt = '0;
      e.vld = '0;
      e.sel = '0;
      e.err = m_err;
      e.tmo = m_tmo;
      for (int o = 0; o < 5; o++) begin
         e.sel[3*o +: 3] = 3'(m_own[o]);
         xf[o] = !r && m_lock[o] && req[m_own[o]] && (d[m_own[o]] == o) && rdy[o];
         if (xf[o]) begin
            e.vld[o]        = 1'b1;
            e.gnt[m_own[o]] = 1'b1;
         end
      end
      exp_q.push_back(e);
      egnt = e.gnt;

      m_err = 1'b0;
      m_tmo = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (!r && req[i] && (d[i] > 4 || d[i] == i)) m_err = 1'b1;
      end
      if (r) begin
         model_reset();
      end else begin
         for (int o = 0; o < 5; o++) begin
            if (!m_lock[o]) begin
               found = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  cand = (m_ptr[o] + k) % 5;
                  if (!found && cand != o && req[cand] && d[cand] == o) begin
                     found      = 1'b1;
                     m_lock[o]  = 1'b1;
                     m_own[o]   = cand;
                     m_stall[o] = 0;
                  end
               end
            end else if (xf[o] && tail[m_own[o]]) begin
               m_lock[o] = 1'b0;
               m_ptr[o]  = (m_own[o] + 1) % 5;
            end
`ifdef SA_LOCK_TIMEOUT_EN
            else if (xf[o]) begin
               m_stall[o] = 0;
            end else if (m_stall[o] == TB_TIMEOUT - 1) begin
               m_lock[o]  = 1'b0;
               m_ptr[o]   = (m_own[o] + 1) % 5;
               m_stall[o] = 0;
               m_tmo      = 1'b1;
            end else begin
               m_stall[o]++;
            end
`endif
         end
      end
   endtask

   function automatic bit is_illegal(input int i);
      return (pdest[i] > 4) || (pdest[i] == i);
   endfunction

   task automatic run(input int n, input bit rnd);
      logic [4:0]  req, tail, rdy, eg;
      logic [14:0] dest;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < 5; i++) begin
            if (rnd && rem[i] == 0 && $urandom_range(0, 1) == 1) begin
               rem[i]     = int'($urandom_range(1, 4));
               ill_age[i] = 0;
               if ($urandom_range(0, 7) == 0) pdest[i] = int'($urandom_range(0, 7));
               else                          pdest[i] = (i + 1 + int'($urandom_range(0, 3))) % 5;
            end
            req[i]          = (rem[i] > 0) && !(rnd && $urandom_range(0, 7) == 0);
            dest[3*i +: 3]  = 3'(pdest[i]);
            tail[i]         = (rem[i] == 1);
            rdy[i]          = rnd ? ($urandom_range(0, 9) < 8) : 1'b1;
         end
         rdy = rdy & ~rdy_block;
         cycle(1'b0, req, dest, tail, rdy, eg);
         for (int i = 0; i < 5; i++) begin
            if (eg[i] && rem[i] > 0) rem[i]--;
            if (rem[i] > 0 && is_illegal(i)) begin
               ill_age[i]++;
               if (ill_age[i] >= 4) rem[i] = 0;
            end
         end
      end
   endtask

   task automatic do_reset(input int n);
      logic [4:0] eg;
      for (int c = 0; c < n; c++) begin
         cycle(1'b1, 5'h1f, 15'($urandom), 5'($urandom), 5'($urandom), eg);
      end
      for (int i = 0; i < 5; i++) rem[i] = 0;
   endtask

   // Monitor: every cycle the DUT presents outputs, pop and compare.
   initial begin
      exp_t e;
      int   cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt_o",       cyc, 32'(sa_if.gnt_o),       32'(e.gnt));
            chk("out_valid_o", cyc, 32'(sa_if.out_valid_o), 32'(e.vld));
            chk("port_select", cyc,
                32'({sa_if.L_port_select, sa_if.W_port_select, sa_if.E_port_select,
                     sa_if.S_port_select, sa_if.N_port_select}), 32'(e.sel));
            chk("err_o",       cyc, 32'(sa_if.err_o),       32'(e.err));
            chk("timeout_o",   cyc, 32'(sa_if.timeout_o),   32'(e.tmo));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst               = 1'b1;
      sa_if.req_i       = 5'h1f;
      sa_if.dest_i      = '0;
      sa_if.tail_i      = '0;
      sa_if.out_ready_i = '1;
      for (int i = 0; i < 5; i++) begin
         rem[i]     = 0;
         pdest[i]   = (i + 1) % 5;
         ill_age[i] = 0;
      end
      @(posedge clk);
      model_reset();
      do_reset(1);

      // Single-flit L->S packet.
      rem[4] = 1; pdest[4] = 1;
      run(4, 1'b0);

      // N, W, L contend for E with 3-flit packets.
      rem[0] = 3; pdest[0] = 2;
      rem[3] = 3; pdest[3] = 2;
      rem[4] = 3; pdest[4] = 2;
      run(14, 1'b0);

      // N->S with S backpressured mid-packet.
      rem[0] = 6; pdest[0] = 1;
      run(3, 1'b0);
      rdy_block = 5'b00010;
      run(4, 1'b0);
      rdy_block = '0;
      run(6, 1'b0);

      // E requesting itself is illegal.
      rem[2] = 3; pdest[2] = 2; ill_age[2] = 0;
      run(6, 1'b0);

      run(700, 1'b1);
      do_reset(2);
      run(700, 1'b1);
      run(6, 1'b0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
Per-router switch allocator that sequences the 5x5 crossbar (ports N=0, S=1, E=2, W=3, L=4).
- Collects per-input output-port requests and runs an independent round-robin arbiter per output.
- Locks each output to one input for a whole packet (head to tail flit).
- Drives the crossbar's five 3-bit port_select lines plus per-input grants and per-output valids.

Parameters:
NUM_PORTS, 5, number of router ports; fixed at 5, parameter exists for assertions only.
TIMEOUT_CYCLES, 64, stall limit used only when the optional feature is compiled in; range 2..255.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset; synchronous, active-high.
req_i  input  5  bit i: input port i holds a valid flit.
dest_i  input  15  bits [3i+2:3i]: requested output port of input i (0..4).
tail_i  input  5  bit i: input i's current flit is the packet's tail. Single-flit packet sets tail on the head flit.
out_ready_i  input  5  bit o: downstream of output o can accept a flit this cycle.
N_port_select, S_port_select, E_port_select, W_port_select, L_port_select  output  3 each  crossbar select; value = owning input index.
gnt_o  output  5  bit i: input i's flit transfers this cycle (dequeue strobe).
out_valid_o  output  5  bit o: output o carries a valid flit this cycle.
err_o  output  1  one-cycle pulse: illegal request seen (dest>4 or dest==own index).
timeout_o  output  1  one-cycle pulse: lock forcibly released (optional feature only; else tied 0).

Behaviour:
- Per output o, registers: lock_vld[o], owner[o] (3b), rr_ptr[o] (3b).
- Reset values: lock_vld=0, owner=o, rr_ptr=0. Hence all port_select outputs = own index; gnt_o=0; out_valid_o=0; err_o=0; timeout_o=0.
- Eligible request: req_i[i] && dest_i[i]==o && dest_i[i]!=i && dest_i[i]<=4.
- Illegal request (dest>4 or dest==i): never granted; err_o pulses the cycle after it is seen, and again every cycle it persists.
- Output states:
  - IDLE (lock_vld=0): if any eligible requester exists, pick the first at or after rr_ptr[o], scanning upward mod 5 and skipping o. Register lock_vld=1 and owner=winner. No grant in the arbitration cycle.
  - LOCKED (lock_vld=1): combinationally xfer[o] = req_i[owner] && dest_i[owner]==o && out_ready_i[o].
    - gnt_o[owner] = xfer[o]; out_valid_o[o] = xfer[o].
    - xfer with tail_i[owner]: next cycle lock_vld=0 and rr_ptr[o] = (owner+1) mod 5.
    - Owner deasserts req_i or changes dest mid-packet: no transfer; lock holds.
- port_select[o] = owner[o] always, including while idle, so the select is stable before the grant.
- Latency: head flit request at cycle N yields earliest grant at N+1. Body flits stream at 1 per cycle while ready. After a tail transfer at cycle T, the output can re-arbitrate at T+1 and grant at T+2.
- An input is granted by at most one output per cycle; legality of its single dest guarantees this.
- Simultaneous: up to 5 outputs arbitrate and transfer in the same cycle independently.
- rst asserted mid-packet: all locks dropped and pointers return to 0 next edge; outputs go to reset values in the same cycle rst is sampled (gnt/out_valid forced 0 while rst=1).

Optional Feature:
Macro SA_LOCK_TIMEOUT_EN.
- Defined: per-output 8-bit stall counter.
  - Clears on lock acquire and on every xfer; increments each LOCKED cycle without xfer.
  - At count==TIMEOUT_CYCLES-1 the lock is released (lock_vld=0, rr_ptr = owner+1) and timeout_o pulses for one cycle.
  - Multiple simultaneous timeouts produce a single pulse.
- Undefined: no counters; locks persist indefinitely; timeout_o tied 0.

Test Plan:
1. Reset: assert rst 2 cycles with req_i=5'b11111 -> gnt_o=0, out_valid_o=0, N..L_port_select = 0,1,2,3,4.
2. Single-flit packet: req_i[4]=1, dest_i[4]=1 (L->S), tail=1, out_ready=all 1, at cycle 0 -> gnt_o=5'b10000 and S_port_select=4 at cycle 1 only; rr_ptr[S]=0 afterwards.
3. Contention: inputs N, E, W all request E... corrected: N, W, L request E with 3-flit packets, ready=1 -> E_port_select sequence 0,0,0 then 3,3,3 then 4,4,4, one idle arbitration cycle between packets; second round starts at N.
4. Backpressure: locked N->S mid-packet, out_ready_i[1]=0 for 4 cycles -> gnt_o[0]=0 and lock held; S_port_select stays 0; transfer resumes the cycle ready returns.
5. Illegal: req_i[2]=1, dest_i[2]=2 -> never granted; err_o=1 every cycle after the first.
6. SA_LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=4: lock W->N, then req_i[3]=0 -> timeout_o pulses on the 4th stalled cycle and N returns to IDLE.
